// File: rtl/seven_seg_reader.sv
// seven_seg_reader: samples a multiplexed, active-low 7-segment display bus and
// rebuilds whole frames of hex nibbles. Each slot is committed once per stable
// dwell. A frame is published when every slot has been seen, using a
// valid/ready handshake.
// Optional feature: define SEVEN_SEG_READER_ERRCNT_EN to add the err_cnt port,
// which counts commits of undecodable patterns and saturates at FFh.
module seven_seg_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] frame_data,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready
`ifdef SEVEN_SEG_READER_ERRCNT_EN
    ,
    output logic [7:0]              err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, COLLECT, PENDING} state_t;

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_ARM = 8'(STABLE_CYCLES - 2);

    // Returns {listed, nibble}; unlisted patterns decode to {0, 0h}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40:   decode = 5'h10;
            7'h79:   decode = 5'h11;
            7'h24:   decode = 5'h12;
            7'h30:   decode = 5'h13;
            7'h19:   decode = 5'h14;
            7'h12:   decode = 5'h15;
            7'h02:   decode = 5'h16;
            7'h78:   decode = 5'h17;
            7'h00:   decode = 5'h18;
            7'h10:   decode = 5'h19;
            7'h08:   decode = 5'h1A;
            7'h03:   decode = 5'h1B;
            7'h46:   decode = 5'h1C;
            7'h21:   decode = 5'h1D;
            7'h06:   decode = 5'h1E;
            7'h0E:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic [7:0]              cnt_q, cnt_d;
    logic                    commit_q, commit_d;
    logic [4*NUM_DIGITS-1:0] work_data_q, work_data_d;
    logic [NUM_DIGITS-1:0]   work_err_q, work_err_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_w;
    logic [4*NUM_DIGITS-1:0] frame_data_q, frame_data_d;
    logic [NUM_DIGITS-1:0]   frame_err_q, frame_err_d;
    logic                    frame_valid_q, frame_valid_d;
    state_t                  state_q, state_d;
    logic                    match;
    logic                    pending;
    logic                    load;
    logic [4:0]              dec;

    // Stability detection: a commit is flagged when the dwell counter steps into its saturated value.
    always_comb begin
        match    = (seg == seg_q) && (dig_sel == sel_q) && $onehot(dig_sel);
        cnt_d    = cnt_q;
        if (!match) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
        commit_d = match && (cnt_q == CNT_ARM);
    end

    // Working bank update, frame publication and FSM next state.
    always_comb begin
        dec         = decode(seg_q);
        work_data_d = work_data_q;
        work_err_d  = work_err_q;
        seen_w      = seen_q;
        if (commit_q) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_q[i]) begin
                    work_data_d[4*i +: 4] = dec[3:0];
                    work_err_d[i]         = ~dec[4];
                    seen_w[i]             = 1'b1;
                end
            end
        end

        pending       = (state_q == PENDING);
        load          = (&seen_w) && (!pending || frame_ready);
        frame_data_d  = frame_data_q;
        frame_err_d   = frame_err_q;
        frame_valid_d = frame_valid_q;
        state_d       = state_q;
        seen_d        = seen_w;
        if (load) begin
            // A completing commit can coincide with the handshake: reload without a bubble.
            frame_data_d  = work_data_d;
            frame_err_d   = work_err_d;
            frame_valid_d = 1'b1;
            seen_d        = '0;
            state_d       = PENDING;
        end else if (!pending || frame_ready) begin
            frame_valid_d = 1'b0;
            state_d       = (seen_w != '0) ? COLLECT : IDLE;
        end
    end

    // All control and capture state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q         <= 7'h7F;
            sel_q         <= '0;
            cnt_q         <= '0;
            commit_q      <= 1'b0;
            work_data_q   <= '0;
            work_err_q    <= '0;
            seen_q        <= '0;
            frame_data_q  <= '0;
            frame_err_q   <= '0;
            frame_valid_q <= 1'b0;
            state_q       <= IDLE;
        end else begin
            seg_q         <= seg;
            sel_q         <= dig_sel;
            cnt_q         <= cnt_d;
            commit_q      <= commit_d;
            work_data_q   <= work_data_d;
            work_err_q    <= work_err_d;
            seen_q        <= seen_d;
            frame_data_q  <= frame_data_d;
            frame_err_q   <= frame_err_d;
            frame_valid_q <= frame_valid_d;
            state_q       <= state_d;
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_err   = frame_err_q;
    assign frame_valid = frame_valid_q;

`ifdef SEVEN_SEG_READER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating count of committed undecodable patterns.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (commit_q && !dec[4] && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/seven_seg_reader.md
SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits captured per frame (2..8).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 4, cycles a (seg, dig_sel) pair must hold before capture (2..255).
REQ-003 The block SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port seg  input  7  active-low segment pattern; bit0=a through bit6=g.
REQ-006 The block SHALL have port dig_sel  input  NUM_DIGITS  active-high one-hot digit strobe; bit i selects slot i.
REQ-007 The block SHALL have port frame_data  output  4*NUM_DIGITS  captured nibbles; slot i in bits [4i+3:4i].
REQ-008 The block SHALL have port frame_err  output  NUM_DIGITS  bit i set when slot i held an undecodable pattern.
REQ-009 The block SHALL have port frame_valid  output  1  frame available.
REQ-010 The block SHALL have port frame_ready  input  1  consumer accepts frame.
REQ-011 The block SHALL have port err_cnt  output  8  invalid-pattern count; present only per REQ-027.

Function
REQ-012 The block SHALL register seg and dig_sel each cycle into seg_q/sel_q; a cycle "matches" when seg==seg_q, dig_sel==sel_q and dig_sel is exactly one-hot.
REQ-013 The stability counter SHALL increment on match, clear to 0 on non-match, and saturate at STABLE_CYCLES-1.
REQ-014 A commit SHALL occur in the cycle the counter equals STABLE_CYCLES-1 and increments to it from STABLE_CYCLES-2, i.e. once per dwell; slot write lands on the (STABLE_CYCLES+1)th rising edge after the pattern first appears.
REQ-015 Commit SHALL decode active-low gfedcba patterns: 0=40h 1=79h 2=24h 3=30h 4=19h 5=12h 6=02h 7=78h 8=00h 9=10h A=08h b=03h C=46h d=21h E=06h F=0Eh.
REQ-016 On commit, a listed pattern SHALL write its nibble to the working slot and clear its working err bit; an unlisted pattern SHALL write 0h and set the err bit; either sets the slot's seen bit.
REQ-017 dig_sel all-zero or multi-hot SHALL never commit and SHALL clear the counter.
REQ-018 The FSM SHALL have states IDLE (no seen bits, frame_valid=0), COLLECT (some seen bits, frame_valid=0), PENDING (frame_valid=1).
REQ-019 When all seen bits are set and (frame_valid=0 or frame_ready=1), the working bank SHALL be copied to frame_data/frame_err, frame_valid SHALL be 1 next cycle, and seen bits SHALL clear.
REQ-020 frame_valid=1 with frame_ready=1 and working bank incomplete SHALL drop frame_valid next cycle (to IDLE or COLLECT per seen bits).
REQ-021 While PENDING and frame_ready=0, frame_data/frame_err SHALL hold stable; commits continue updating the working bank, latest value per slot wins.
REQ-022 A commit to the last unseen slot in the same cycle as a handshake SHALL load the new frame with no bubble (frame_valid stays 1).

Reset
REQ-023 rst SHALL asynchronously force frame_data=0, frame_err=0, frame_valid=0, err_cnt=0, working bank, seen bits, counter, seg_q=7Fh, sel_q=0, FSM=IDLE.
REQ-024 Reset asserted mid-frame SHALL discard all partial captures; no frame SHALL be produced from pre-reset commits.
REQ-025 After rst deasserts, the first commit SHALL require a full STABLE_CYCLES dwell.

Configuration
REQ-026 Macro SEVEN_SEG_READER_ERRCNT_EN SHALL control the err_cnt port and counter.
REQ-027 With SEVEN_SEG_READER_ERRCNT_EN defined, err_cnt SHALL increment on every commit of an unlisted pattern, saturate at FFh, and reset to 0; without it, err_cnt and its logic SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-028 Bench SHALL drive slots 0..3 with 40h,79h,24h,30h, each held 6 cycles -> one frame, frame_data=3210h, frame_err=0h.
REQ-029 Bench SHALL hold a pattern exactly STABLE_CYCLES-1 cycles, then change it -> no commit; hold 20 cycles -> exactly one commit.
REQ-030 Bench SHALL drive slot 2 with 7Fh, others valid -> frame_err=4h, nibble 2=0h, err_cnt=1 with macro.
REQ-031 Bench SHALL hold frame_ready=0 for 50 cycles while a second frame 5678h completes -> first frame stable; after handshake, next frame=5678h.
REQ-032 Bench SHALL drive dig_sel=3h or 0h for 10 cycles -> no commit, counter cleared.
REQ-033 Bench SHALL assert rst after slots 0..2 are captured -> outputs zero, no frame until all four slots recaptured.
